// File: rtl/gate_checker.sv
// Response checker for the NOT / NAND / D-flop gate harness: compares DUT responses against locally
// computed expectations, counts mismatches per gate and reports a verdict. Optional: GATE_CHECKER_STOP_ON_ERR_EN.
module gate_checker #(
    parameter int CNT_W      = 8,
    parameter int CYC_W      = 16,
    parameter int WARMUP     = 2,
    parameter int NUM_CHECKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             check_en,
    input  logic             in_not,
    input  logic             in1_nand,
    input  logic             in2_nand,
    input  logic             D_flop,
    input  logic             out_not,
    input  logic             out_nand,
    input  logic             Q_flop,
    output logic [CNT_W-1:0] err_not_cnt,
    output logic [CNT_W-1:0] err_nand_cnt,
    output logic [CNT_W-1:0] err_flop_cnt,
    output logic [CNT_W-1:0] total_err,
    output logic [CYC_W-1:0] first_err_cycle,
    output logic [2:0]       first_err_mask,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WW-1:0]    WARM_LAST = WW'(WARMUP - 1);
    localparam logic [CYC_W-1:0] CHK_LAST  = CYC_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [WW-1:0]      r_warm_cnt;
    logic [CYC_W-1:0]   r_chk_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_exp_q;
    logic               r_exp_q_valid;
    logic [CNT_W-1:0]   r_total;
    logic [CYC_W-1:0]   r_first_cycle;
    logic [2:0]         r_first_mask;
    logic               r_err_seen;

    logic               w_check;
    logic [2:0]         w_m;
    logic [1:0]         w_pop;
    logic [CNT_W+1:0]   w_sum;
    logic [CNT_W-1:0]   w_total_next;
    logic               w_stop;
    logic [3*CNT_W-1:0] w_cnt_flat;

    // The flop check is meaningless until exp_q has captured a real D after reset.
    assign w_m[0] = out_not  != ~in_not;
    assign w_m[1] = out_nand != ~(in1_nand & in2_nand);
    assign w_m[2] = r_exp_q_valid & (Q_flop != r_exp_q);

    assign w_check      = (r_state == S_CHECK) && check_en;
    assign w_pop        = {1'b0, w_m[0]} + {1'b0, w_m[1]} + {1'b0, w_m[2]};
    assign w_sum        = {2'b00, r_total} + {{CNT_W{1'b0}}, w_pop};
    assign w_total_next = (w_sum > {2'b00, CNT_MAX}) ? CNT_MAX : w_sum[CNT_W-1:0];

`ifdef GATE_CHECKER_STOP_ON_ERR_EN
    assign w_stop = |w_m;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_q       <= 1'b0;
            r_exp_q_valid <= 1'b0;
        end else begin
            r_exp_q       <= D_flop;
            r_exp_q_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_warm_cnt <= '0;
            r_chk_idx  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (check_en) begin
                        r_state    <= S_WARMUP;
                        r_warm_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_WARMUP: begin
                    if (r_warm_cnt == WARM_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WW'(1);
                    end
                end
                S_CHECK: begin
                    if (check_en) begin
                        r_chk_idx <= r_chk_idx + CYC_W'(1);
                        if ((r_chk_idx == CHK_LAST) || w_stop) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_total_next == '0);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_check && w_m[gi] && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            assign w_cnt_flat[gi*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_total       <= '0;
            r_first_cycle <= '0;
            r_first_mask  <= '0;
            r_err_seen    <= 1'b0;
        end else if (w_check) begin
            r_total <= w_total_next;
            if ((|w_m) && !r_err_seen) begin
                r_first_cycle <= r_chk_idx;
                r_first_mask  <= w_m;
                r_err_seen    <= 1'b1;
            end
        end
    end

    assign err_not_cnt     = w_cnt_flat[0*CNT_W +: CNT_W];
    assign err_nand_cnt    = w_cnt_flat[1*CNT_W +: CNT_W];
    assign err_flop_cnt    = w_cnt_flat[2*CNT_W +: CNT_W];
    assign total_err       = r_total;
    assign first_err_cycle = r_first_cycle;
    assign first_err_mask  = r_first_mask;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;

endmodule

// File: doc/gate_checker.md
# gate_checker

Synthesizable response checker for the gate test harness: the receiving end of the gate stimulus interface. It samples the stimulus driven to the NOT, NAND and D-flip-flop DUTs together with their responses. On every clock edge it compares each response with a locally computed expected value. It counts mismatches per gate, records the first failure, and reports a pass/fail verdict after a programmed number of checked cycles.

## Interface
Parameters:
- CNT_W, 8, width of each per-gate error counter and of total_err
- CYC_W, 16, width of the checked-cycle index and first_err_cycle
- WARMUP, 2, cycles after check start before comparisons begin; legal range ≥1
- NUM_CHECKS, 4, number of compared cycles before done; legal range ≥1, < 2^CYC_W

Ports:
- clk  input  1  rising-edge clock shared with the stimulus generator
- reset  input  1  synchronous, active-high reset
- check_en  input  1  starts the check from IDLE; pauses comparisons when low in CHECK
- in_not  input  1  NOT stimulus
- in1_nand, in2_nand  input  1 each  NAND stimulus
- D_flop  input  1  flip-flop D stimulus
- out_not, out_nand, Q_flop  input  1 each  DUT responses
- err_not_cnt, err_nand_cnt, err_flop_cnt  output  CNT_W each  saturating mismatch counts
- total_err  output  CNT_W  saturating sum of all mismatches
- first_err_cycle  output  CYC_W  check index (0-based) of the first mismatching cycle
- first_err_mask  output  3  {flop, nand, not} mismatch bits of that first cycle
- busy  output  1  high in WARMUP and CHECK
- done  output  1  verdict valid, held until reset
- pass  output  1  done && total_err==0

## Operation
- Expected values: exp_not = ~in_not; exp_nand = ~(in1_nand & in2_nand); exp_q = D_flop registered on every clk edge, regardless of state.
- exp_q_valid clears on reset and sets after the first post-reset edge. While it is clear, the flop mismatch is forced to 0.
- Mismatch vector m = {Q_flop!=exp_q, out_nand!=exp_nand, out_not!=exp_not}, evaluated combinationally and acted on only at a CHECK edge with check_en=1.
- FSM states and transitions:
  - IDLE: go to WARMUP when check_en=1.
  - WARMUP: count WARMUP edges, ignoring check_en, then go to CHECK.
  - CHECK: each edge with check_en=1 is a check. Increment the per-gate counter for each set bit of m, and add popcount(m) to total_err. Then increment chk_idx. After the check with chk_idx==NUM_CHECKS-1, go to DONE.
  - CHECK with check_en=0: no compare, no index advance.
  - DONE: terminal until reset.
- Saturation: a counter at 2^CNT_W-1 holds its value. The total_err addition clamps at 2^CNT_W-1.
- First error capture: on the first check with m!=0, latch first_err_cycle=chk_idx and first_err_mask=m. Later errors do not overwrite them. Both stay 0 if no error occurs.
- Reset mid-operation: every register returns to its reset value and the FSM goes to IDLE. The current check is abandoned with no verdict.

## Timing
- Reset values: all counters, first_err_*, busy, done, pass = 0; FSM = IDLE; exp_q = 0.
- Comparisons use the values present just before the edge. Stimulus launched at edge k is therefore checked at edge k+1. The flop DUT's Q at edge k+1 is compared against exp_q, which holds the D captured at edge k.
- Outputs are registered. A mismatch at edge k is visible in the counters after edge k.
- Latency with check_en held high: check_en high before edge 0 puts the FSM in WARMUP after edge 0. CHECK is entered after edge WARMUP. done=1 after edge WARMUP+NUM_CHECKS.
- busy and done are never high together. pass updates in the same cycle as done.

## Configuration
- GATE_CHECKER_STOP_ON_ERR_EN defined: the first check with m!=0 moves CHECK→DONE on that edge, with its counts recorded. Resulting state: done=1, pass=0.
- Macro undefined: all NUM_CHECKS checks always run regardless of errors.

## Test plan
- Clean run, correct DUT model, WARMUP=2, NUM_CHECKS=4, check_en high before edge 0 → done=1 after edge 6, pass=1, all counts 0, first_err_mask=3'b000.
- out_nand inverted only during check index 2 → err_nand_cnt=1, total_err=1, first_err_cycle=2, first_err_mask=3'b010, pass=0. With the macro defined, done=1 after that same edge.
- Q_flop stuck at 0 while D_flop toggles 0,1,0,1 starting in WARMUP → err_flop_cnt=2, first_err_mask=3'b100.
- CNT_W=2, NUM_CHECKS=8, out_not always wrong → err_not_cnt=3 and total_err=3 (saturated), no wrap.
- check_en dropped for 3 edges in CHECK → chk_idx frozen; done delayed by exactly 3 edges.
- reset pulsed at check index 1 after a recorded error → all outputs 0, FSM in IDLE; next run yields pass=1 with a correct DUT.
